// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_access_pkg;
  localparam int DATA_W             = 16;
  localparam int ADDR_W             = 16;
  localparam int BUS_W              = 8;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int TO_CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/mem_access_unit_timeout.sv
// Bus watchdog: counts beat cycles without mem_ack and flags the abort cycle.
module mem_timeout_ctr
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last unacknowledged cycle so mem_req is held exactly TIMEOUT_CYCLES cycles.
  assign expired = waiting && (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage responder: runs LW/SW/LBU/SB as big-endian byte beats on a req/ack bus.
// Optional watchdog abort is compiled in with MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              byteOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output state_e            dbg_state
);
  // Bus handshake: a beat is outstanding while mem_req=1; mem_we/mem_addr/mem_wdata
  // stay stable until the cycle mem_ack=1 is seen, which completes that beat.
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [BUS_W-1:0]    hi_q, hi_d;
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic                err_q, err_d;
  logic                req_in, in_bus, bus_enter, to_expired;

  assign req_in = memRead | memWrite;
  assign in_bus = (state_q == BYTE0) || (state_q == BYTE1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hi_d    = hi_q;
    we_d    = we_q;
    byte_d  = byte_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          if ((memRead && memWrite) || (!byteOp && addr[0])) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = addr;
            wdata_d = wdata;
            we_d    = memWrite;
            byte_d  = byteOp;
            err_d   = 1'b0;
            state_d = BYTE0;
          end
        end
      end
      BYTE0: begin
        if (mem_ack) begin
          if (!we_q && byte_q) rdata_d = {8'h00, mem_rdata};
          if (!we_q && !byte_q) hi_d = mem_rdata;
          state_d = byte_q ? DONE : BYTE1;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      BYTE1: begin
        // rdata only changes once the whole word has arrived, so an abort leaves it intact.
        if (mem_ack) begin
          if (!we_q) rdata_d = {hi_q, mem_rdata};
          state_d = DONE;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end

  assign bus_enter = ((state_d == BYTE0) || (state_d == BYTE1)) && (state_d != state_q);

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus_enter),
    .waiting (in_bus && !mem_ack),
    .expired (to_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = bus_enter ^ (TIMEOUT_CYCLES != 0);
  assign to_expired     = 1'b0;
`endif

  assign stall     = ((state_q == IDLE) && req_in) || in_bus;
  assign mem_req   = in_bus;
  assign mem_we    = in_bus && we_q;
  assign mem_addr  = (state_q == BYTE0) ? addr_q :
                     (state_q == BYTE1) ? addr_q + 16'd1 : '0;
  assign mem_wdata = !(in_bus && we_q) ? '0 :
                     ((state_q == BYTE1) || byte_q) ? wdata_q[7:0] : wdata_q[15:8];
  assign done      = (state_q == DONE);
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model expands each access into its expected cycle trace.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int TB_TO_PARAM = 4;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TLIM = TB_TO_PARAM;
`else
  localparam int TLIM = 1 << 30;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0, byteOp = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata;
  logic        stall, done, err, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  state_e      dbg_state;

  mem_access_unit #(.TIMEOUT_CYCLES(TB_TO_PARAM)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite), .byteOp(byteOp),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [15:0] maddr;
    logic [7:0]  mwd;
    logic        done;
    logic        err;
    logic        chk_rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_rdata = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic st, input logic rq, input logic we, input logic [15:0] ma,
                          input logic [7:0] wd, input logic dn, input logic er, input logic cr);
    exp_t e;
    e = '{stall: st, req: rq, we: we, maddr: ma, mwd: wd, done: dn, err: er, chk_rd: cr,
          rdata: m_rdata};
    exp_q.push_back(e);
  endtask

  task automatic compare_cycle();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q: got empty expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("stall", {15'd0, stall}, {15'd0, e.stall});
      chk("mem_req", {15'd0, mem_req}, {15'd0, e.req});
      chk("done", {15'd0, done}, {15'd0, e.done});
      if (e.req) begin
        chk("mem_we", {15'd0, mem_we}, {15'd0, e.we});
        chk("mem_addr", mem_addr, e.maddr);
        if (e.we) chk("mem_wdata", {8'd0, mem_wdata}, {8'd0, e.mwd});
      end
      if (e.done) chk("err", {15'd0, err}, {15'd0, e.err});
      if (e.chk_rd) chk("rdata", rdata, e.rdata);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0;
      byteOp = 1'($urandom_range(0, 1));
      addr = 16'($urandom); wdata = 16'($urandom);
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
      push_exp(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); compare_cycle();
    end
  endtask

  // One access: the presenting IDLE cycle, the beats, then DONE; w0/w1 = no-ack cycles per beat.
  task automatic run_txn(input logic rd, input logic wr, input logic bop, input logic [15:0] a,
                         input logic [15:0] wd, input int w0, input int w1,
                         input logic [7:0] rb0, input logic [7:0] rb1, output int lat);
    logic bad, timed_out;
    int   nb, w;
    logic [7:0] rb, ebyte;
    lat = 0;
    timed_out = 1'b0;
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; byteOp = bop; addr = a; wdata = wd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
    push_exp(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); compare_cycle();
    bad = (rd && wr) || (!bop && a[0]);
    if (!bad) begin
      nb = bop ? 1 : 2;
      for (int b = 0; b < nb; b++) begin
        w  = (b == 0) ? w0 : w1;
        rb = (b == 0) ? rb0 : rb1;
        ebyte = (bop || b == 1) ? wd[7:0] : wd[15:8];
        for (int c = 0; c <= w; c++) begin
          @(posedge clk); #1;
          lat++;
          addr = 16'($urandom); wdata = 16'($urandom);
          mem_ack = (c == w);
          mem_rdata = (c == w) ? rb : 8'($urandom);
          push_exp(1'b1, 1'b1, wr, a + 16'(b), ebyte, 1'b0, 1'b0, 1'b0);
          @(negedge clk); compare_cycle();
          if (c != w && c + 1 == TLIM) begin
            timed_out = 1'b1;
            break;
          end
        end
        if (timed_out) break;
      end
    end
    @(posedge clk); #1;
    lat++;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
    if (!bad && !timed_out && rd) m_rdata = bop ? {8'h00, rb0} : {rb0, rb1};
    push_exp(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, bad || timed_out, 1'b1);
    @(negedge clk); compare_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int kind;
    logic rd, wr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", {8'd0, mem_wdata}, 16'h0000);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    run_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 0, 8'hAB, 8'hCD, lat);
    chk("lw_lat", 16'(lat), 16'd3);
    chk("lw_rdata", rdata, 16'hABCD);
    chk("lw_done", {15'd0, done}, 16'd1);

    run_txn(1'b1, 1'b0, 1'b1, 16'h0021, 16'h0000, 0, 0, 8'hF0, 8'h00, lat);
    chk("lbu_lat", 16'(lat), 16'd2);
    chk("lbu_rdata", rdata, 16'h00F0);
    chk("lbu_err", {15'd0, err}, 16'd0);

    run_txn(1'b0, 1'b1, 1'b0, 16'h0040, 16'h1234, 1, 1, 8'h00, 8'h00, lat);
    chk("sw_lat", 16'(lat), 16'd5);
    chk("sw_rdata_kept", rdata, 16'h00F0);

    run_txn(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 0, 0, 8'h00, 8'h00, lat);
    chk("misalign_lat", 16'(lat), 16'd1);
    chk("misalign_err", {15'd0, err}, 16'd1);

    run_txn(1'b1, 1'b1, 1'b1, 16'h0008, 16'h5555, 0, 0, 8'h00, 8'h00, lat);
    chk("conflict_lat", 16'(lat), 16'd1);
    chk("conflict_err", {15'd0, err}, 16'd1);
    idle_cycles(1);

`ifdef MEM_ACCESS_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 100, 0, 8'h11, 8'h22, lat);
    chk("timeout_lat", 16'(lat), 16'd5);
    chk("timeout_err", {15'd0, err}, 16'd1);
    chk("timeout_rdata", rdata, 16'h00F0);
`else
    run_txn(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 300, 0, 8'h5A, 8'hC3, lat);
    chk("longwait_lat", 16'(lat), 16'd303);
    chk("longwait_err", {15'd0, err}, 16'd0);
    chk("longwait_rdata", rdata, 16'h5AC3);
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      rd = (kind < 4) || (kind == 8);
      wr = (kind >= 4 && kind < 9);
      if (kind == 9) begin
        idle_cycles(1);
      end else begin
        run_txn(rd, wr, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom), 8'($urandom), lat);
      end
      idle_cycles($urandom_range(0, 2));
    end

    // Reset in the second beat of a store: the access is dropped, never replayed.
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b1; byteOp = 1'b0; addr = 16'h0040; wdata = 16'h1234;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 8'h00;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rst_b1_req", {15'd0, mem_req}, 16'd1);
    chk("rst_b1_addr", mem_addr, 16'h0041);
    chk("rst_b1_wdata", {8'd0, mem_wdata}, 16'h0034);
    #1;
    rst_n = 1'b0; memWrite = 1'b0;
    #1;
    chk("rst_async_req", {15'd0, mem_req}, 16'd0);
    chk("rst_async_stall", {15'd0, stall}, 16'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    m_rdata = 16'h0000;
    @(negedge clk);
    chk("post_rst_state", 16'(dbg_state), 16'(IDLE));
    chk("post_rst_rdata", rdata, 16'h0000);
    chk("post_rst_done", {15'd0, done}, 16'd0);
    chk("post_rst_err", {15'd0, err}, 16'd0);
    chk("post_rst_we", {15'd0, mem_we}, 16'd0);
    chk("post_rst_addr", mem_addr, 16'h0000);
    chk("post_rst_wdata", {8'd0, mem_wdata}, 16'h0000);
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
